imem_port_arbiter: RTL

Arbitrates the byte-wide instruction memory between the core's fetch path and the program loader. A 32-bit fetch is performed as four sequential byte reads, assembled little-endian. Loader byte writes are interleaved between fetches under round-robin arbitration. The block sits between the fetch stage, the loader and the instruction memory macro, and is the only master of the memory port.

---
 rtl/imem_port_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// ----------------------------------------------------------------------------
// imem_port_arbiter
//
// Arbitrates the byte-wide instruction memory port between the fetch path
// and the program loader. A 32-bit fetch is four sequential byte reads,
// assembled little-endian. Loader byte writes are interleaved between
// fetches under round-robin arbitration. This block is the only master of
// the memory port.
//
// Ports:
//   clk          in   1  rising-edge clock
//   reset        in   1  asynchronous, active-high reset
//   fetch_req    in   1  fetch request (level)
//   fetch_addr   in  32  instruction byte address, latched at grant
//   instruction  out 32  assembled instruction, valid with fetch_valid
//   fetch_valid  out  1  one-cycle pulse when a fetch completes
//   fetch_fault  out  1  with fetch_valid when the fetch was rejected
//   load_req     in   1  loader write request (level)
//   load_addr    in  32  loader byte address, latched at grant
//   load_data    in   8  loader byte, latched at grant
//   load_ack     out  1  one-cycle pulse in the write cycle
//   mem_addr     out 32  memory byte address
//   mem_we       out  1  memory write enable
//   mem_wdata    out  8  memory write byte
//   mem_rdata    in   8  memory read byte (combinational from mem_addr)
//   busy         out  1  high while fetching or writing
// ----------------------------------------------------------------------------
module imem_port_arbiter #(
   parameter int unsigned MEM_BYTES = 472,
   parameter logic [31:0] NOP_INST  = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic [31:0] instruction,
   output logic        fetch_valid,
   output logic        fetch_fault,
   input  logic        load_req,
   input  logic [31:0] load_addr,
   input  logic [7:0]  load_data,
   output logic        load_ack,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        busy
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned INST_W = 32;
   localparam int unsigned CNT_W  = 2;

   // Highest legal word-fetch base and first illegal byte address.
   localparam logic [ADDR_W-1:0] LAST_FETCH_ADDR = ADDR_W'(MEM_BYTES - 4);
   localparam logic [ADDR_W-1:0] MEM_LIMIT       = ADDR_W'(MEM_BYTES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   typedef enum logic {
      GRANT_FETCH  = 1'b0,
      GRANT_LOADER = 1'b1
   } grant_t;

   // Architectural state
   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [ADDR_W-1:0]   base, base_d;
   grant_t              last_grant, last_grant_d;
   logic [INST_W-9:0]   asm_buf, asm_buf_d;

   // Next values of the registered outputs
   logic [INST_W-1:0]   instruction_d;
   logic                fetch_valid_d;
   logic                fetch_fault_d;
   logic                load_ack_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic                mem_we_d;
   logic [DATA_W-1:0]   mem_wdata_d;
   logic                busy_d;

   // Grant qualification
   logic                fetch_ok_c;
   logic                load_in_range_c;
   logic                pick_fetch_c;
   logic                pick_load_c;

   // Fetch must be word aligned and the whole word must lie inside memory.
   assign fetch_ok_c      = (fetch_addr[1:0] == 2'b00) && (fetch_addr <= LAST_FETCH_ADDR);
   assign load_in_range_c = (load_addr < MEM_LIMIT);

   // Round-robin pick: on a tie, the requester not granted last wins.
   assign pick_fetch_c = fetch_req && (!load_req || (last_grant == GRANT_LOADER));
   assign pick_load_c  = load_req && !pick_fetch_c;

   // Next-state and next-output logic
   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      base_d        = base;
      last_grant_d  = last_grant;
      asm_buf_d     = asm_buf;
      instruction_d = instruction;
      fetch_valid_d = 1'b0;
      fetch_fault_d = 1'b0;
      load_ack_d    = 1'b0;
      mem_addr_d    = '0;
      mem_we_d      = 1'b0;
      mem_wdata_d   = '0;

      unique case (state)
         S_IDLE: begin
            if (pick_fetch_c) begin
               last_grant_d = GRANT_FETCH;
               if (fetch_ok_c) begin
                  state_d    = S_FETCH;
                  cnt_d      = '0;
                  base_d     = fetch_addr;
                  mem_addr_d = fetch_addr;
               end else begin
                  // Rejected fetch: stay idle, report a fault with a NOP.
                  fetch_valid_d = 1'b1;
                  fetch_fault_d = 1'b1;
                  instruction_d = NOP_INST;
               end
            end else if (pick_load_c) begin
               last_grant_d = GRANT_LOADER;
               state_d      = S_WRITE;
               mem_addr_d   = load_addr;
               mem_wdata_d  = load_data;
               mem_we_d     = load_in_range_c;
               load_ack_d   = 1'b1;
            end
         end

         S_FETCH: begin
            // Capture the byte addressed this cycle; the last byte completes the word.
            unique case (cnt)
               2'd0: asm_buf_d[7:0]   = mem_rdata;
               2'd1: asm_buf_d[15:8]  = mem_rdata;
               2'd2: asm_buf_d[23:16] = mem_rdata;
               default: begin
                  instruction_d = {mem_rdata, asm_buf};
                  fetch_valid_d = 1'b1;
               end
            endcase

            if (cnt == 2'd3) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d      = cnt + 2'd1;
               mem_addr_d = base + ADDR_W'(cnt) + 32'd1;
            end
         end

         S_WRITE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         base        <= '0;
         last_grant  <= GRANT_LOADER;
         asm_buf     <= '0;
         instruction <= '0;
         fetch_valid <= 1'b0;
         fetch_fault <= 1'b0;
         load_ack    <= 1'b0;
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         base        <= base_d;
         last_grant  <= last_grant_d;
         asm_buf     <= asm_buf_d;
         instruction <= instruction_d;
         fetch_valid <= fetch_valid_d;
         fetch_fault <= fetch_fault_d;
         load_ack    <= load_ack_d;
         mem_addr    <= mem_addr_d;
         mem_we      <= mem_we_d;
         mem_wdata   <= mem_wdata_d;
         busy        <= busy_d;
      end
   end

endmodule
